// File: rtl/ram_access_arbiter.sv
// Purpose: round-robin arbiter/sequencer serialising requesters A and B onto a single-port sync RAM.
// Latency: gnt one edge after req is sampled in IDLE; write done one edge later, read done/rdata two edges later.
// Backpressure: one access in flight; a losing or newly arriving req is held off until the FSM returns to IDLE.
module ram_access_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_BUS_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_a,
    input  logic                      req_b,
    input  logic                      we_a,
    input  logic                      we_b,
    input  logic [ADDR_BUS_WIDTH-1:0] addr_a,
    input  logic [ADDR_BUS_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]     wdata_a,
    input  logic [DATA_WIDTH-1:0]     wdata_b,
    output logic                      gnt_a,
    output logic                      gnt_b,
    output logic                      done_a,
    output logic                      done_b,
    output logic [DATA_WIDTH-1:0]     rdata_a,
    output logic [DATA_WIDTH-1:0]     rdata_b,
    output logic                      mem_read_en,
    output logic                      mem_write_en,
    output logic [ADDR_BUS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      last_b_q, last_b_d;    // 1: B was granted most recently
    logic                      owner_b_q, owner_b_d;  // side owning the in-flight access
    logic                      rd_q, rd_d;            // in-flight access is a read
    logic                      gnt_a_q, gnt_a_d;
    logic                      gnt_b_q, gnt_b_d;
    logic                      done_a_q, done_a_d;
    logic                      done_b_q, done_b_d;
    logic [DATA_WIDTH-1:0]     rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0]     rdata_b_q, rdata_b_d;
    logic                      mem_read_en_q, mem_read_en_d;
    logic                      mem_write_en_q, mem_write_en_d;
    logic [ADDR_BUS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]     mem_data_in_q, mem_data_in_d;
    logic                      pick_b;

    // Next-state and registered-output logic; pulses and RAM pins default to 0 every cycle.
    always_comb begin
        state_d        = state_q;
        last_b_d       = last_b_q;
        owner_b_d      = owner_b_q;
        rd_d           = rd_q;
        rdata_a_d      = rdata_a_q;
        rdata_b_d      = rdata_b_q;
        gnt_a_d        = 1'b0;
        gnt_b_d        = 1'b0;
        done_a_d       = 1'b0;
        done_b_d       = 1'b0;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        mem_address_d  = '0;
        mem_data_in_d  = '0;
        pick_b         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // B wins when alone, or when both ask and A was granted last.
                    pick_b         = req_b && (!req_a || !last_b_q);
                    last_b_d       = pick_b;
                    owner_b_d      = pick_b;
                    rd_d           = pick_b ? !we_b : !we_a;
                    gnt_a_d        = !pick_b;
                    gnt_b_d        = pick_b;
                    mem_read_en_d  = pick_b ? !we_b : !we_a;
                    mem_write_en_d = pick_b ? we_b : we_a;
                    mem_address_d  = pick_b ? addr_b : addr_a;
                    mem_data_in_d  = pick_b ? wdata_b : wdata_a;
                    state_d        = CMD;
                end
            end
            CMD: begin
                if (rd_q) begin
                    state_d = RESP;
                end else begin
                    done_a_d = !owner_b_q;
                    done_b_d = owner_b_q;
                    state_d  = IDLE;
                end
            end
            RESP: begin
                if (owner_b_q) begin
                    rdata_b_d = mem_data_out;
                end else begin
                    rdata_a_d = mem_data_out;
                end
                done_a_d = !owner_b_q;
                done_b_d = owner_b_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access and favours A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_b_q       <= 1'b1;
            owner_b_q      <= 1'b0;
            rd_q           <= 1'b0;
            gnt_a_q        <= 1'b0;
            gnt_b_q        <= 1'b0;
            done_a_q       <= 1'b0;
            done_b_q       <= 1'b0;
            rdata_a_q      <= '0;
            rdata_b_q      <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_address_q  <= '0;
            mem_data_in_q  <= '0;
        end else begin
            state_q        <= state_d;
            last_b_q       <= last_b_d;
            owner_b_q      <= owner_b_d;
            rd_q           <= rd_d;
            gnt_a_q        <= gnt_a_d;
            gnt_b_q        <= gnt_b_d;
            done_a_q       <= done_a_d;
            done_b_q       <= done_b_d;
            rdata_a_q      <= rdata_a_d;
            rdata_b_q      <= rdata_b_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            mem_address_q  <= mem_address_d;
            mem_data_in_q  <= mem_data_in_d;
        end
    end

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign done_a       = done_a_q;
    assign done_b       = done_b_q;
    assign rdata_a      = rdata_a_q;
    assign rdata_b      = rdata_b_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_address  = mem_address_q;
    assign mem_data_in  = mem_data_in_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Purpose: randomized and directed bench for ram_access_arbiter against a transaction-level model.
// Latency: model expects gnt one edge after the IDLE sample, write done +1 edge, read done/rdata +2 edges.
// Backpressure: the losing side keeps req asserted; the winner drops req after gnt.
module tb_ram_access_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, done_a, done_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          mem_read_en, mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: pending requests, round-robin memory of last winner, golden memory, held rdata.
    logic          pa, pb, wa, wb, last_b, prev_w;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db, exp_rd_a, exp_rd_b;
    logic [DW-1:0] gold [64];
    logic [DW-1:0] ram  [64];

    always #5 clk = ~clk;

    ram_access_arbiter #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Single-port synchronous RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address] <= mem_data_in;
        if (mem_read_en)  mem_data_out <= ram[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Protocol invariants, checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_rw_excl", {31'd0, mem_read_en && mem_write_en}, 32'd0);
            chk("inv_gnt_excl", {31'd0, gnt_a && gnt_b}, 32'd0);
            chk("inv_done_excl", {31'd0, done_a && done_b}, 32'd0);
            chk("inv_en_with_gnt", {31'd0, mem_read_en || mem_write_en}, {31'd0, gnt_a || gnt_b});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req_a = pa; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = pb; we_b = wb; addr_b = ab; wdata_b = db;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {gnt_a, gnt_b, done_a, done_b, mem_read_en, mem_write_en}, 32'd0);
        chk({tag, "_bus"}, {mem_address, mem_data_in, rdata_a, rdata_b}, 32'd0);
    endtask

    task automatic new_req(input logic side_b);
        logic          w = 1'($urandom_range(0, 1));
        logic [AW-1:0] a = AW'($urandom_range(0, 15));
        logic [DW-1:0] d = DW'($urandom);
        if (side_b) begin pb = 1'b1; wb = w; ab = a; db = d; end
        else        begin pa = 1'b1; wa = w; aa = a; da = d; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pa = 1'b0; pb = 1'b0;
        drive();
        #1;
        chk_all_zero("reset_outputs");
        tick();
        tick();
        rst_n = 1'b1;
        last_b = 1'b1;
        exp_rd_a = '0;
        exp_rd_b = '0;
    endtask

    // One arbitration round driven from the pending requests, fully checked against the model.
    task automatic step_round();
        logic          w, wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        drive();
        if (!pa && !pb) begin
            tick();
            chk("idle_quiet", {gnt_a, gnt_b, done_a, done_b}, 32'd0);
            return;
        end
        w      = (pa && pb) ? !last_b : pb;
        prev_w = last_b;
        last_b = w;
        wr     = w ? wb : wa;
        ad     = w ? ab : aa;
        dt     = w ? db : da;
        tick();
        chk("gnt", {gnt_a, gnt_b}, {30'd0, !w, w});
        chk("cmd_en", {mem_read_en, mem_write_en}, {30'd0, !wr, wr});
        chk("cmd_addr", mem_address, ad);
        chk("cmd_data", mem_data_in, dt);
        chk("cmd_no_done", {done_a, done_b}, 32'd0);
        // Winner drops req and scrambles its fields; these must not matter.
        if (w) begin pb = 1'b0; ab = AW'($urandom); db = DW'($urandom); wb = 1'($urandom); end
        else   begin pa = 1'b0; aa = AW'($urandom); da = DW'($urandom); wa = 1'($urandom); end
        drive();
        tick();
        chk("post_cmd_idle", {gnt_a, gnt_b, mem_read_en, mem_write_en}, 32'd0);
        chk("post_cmd_bus", {mem_address, mem_data_in}, 32'd0);
        if (wr) begin
            gold[ad] = dt;
            chk("wr_done", {done_a, done_b}, {30'd0, !w, w});
        end else begin
            chk("rd_wait", {done_a, done_b}, 32'd0);
            tick();
            chk("rd_done", {done_a, done_b}, {30'd0, !w, w});
            if (w) exp_rd_b = gold[ad];
            else   exp_rd_a = gold[ad];
        end
        chk("rdata_a", rdata_a, exp_rd_a);
        chk("rdata_b", rdata_b, exp_rd_b);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]  = '0;
            gold[i] = '0;
        end
        mem_data_out = '0;
        pa = 0; pb = 0; wa = 0; wb = 0; aa = '0; ab = '0; da = '0; db = '0;
        do_reset();

        // Reset during the response phase of a read by A.
        pa = 1'b1; wa = 1'b0; aa = 6'd5; da = 8'h00;
        drive();
        tick();
        chk("t1_gnt_a", {31'd0, gnt_a}, 32'd1);
        pa = 1'b0;
        drive();
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("t1_reset_mid_read");
        tick();
        chk("t1_no_done_a", {31'd0, done_a}, 32'd0);
        rst_n = 1'b1;
        last_b = 1'b1; exp_rd_a = '0; exp_rd_b = '0;
        pb = 1'b1; wb = 1'b1; ab = 6'd9; db = 8'hC3;
        step_round();

        // A writes then reads back.
        pa = 1'b1; wa = 1'b1; aa = 6'h03; da = 8'h5A;
        step_round();
        pa = 1'b1; wa = 1'b0; aa = 6'h03;
        step_round();
        chk("t2_rdata_a", rdata_a, 32'h5A);

        // Simultaneous requests straight out of reset: A favoured.
        do_reset();
        pa = 1'b1; wa = 1'b1; aa = 6'h01; da = 8'h11;
        pb = 1'b1; wb = 1'b0; ab = 6'h01;
        step_round();
        chk("t3_a_first", {31'd0, last_b}, 32'd0);
        step_round();
        chk("t3_rdata_b", rdata_b, 32'h11);

        // Both held high: strict alternation.
        new_req(1'b0);
        new_req(1'b1);
        for (int i = 0; i < 6; i++) begin
            step_round();
            chk("t4_alternate", {31'd0, last_b}, {31'd0, !prev_w});
            new_req(last_b);
        end
        pa = 1'b0; pb = 1'b0;
        step_round();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if (!pa && ($urandom_range(0, 99) < 55)) new_req(1'b0);
            if (!pb && ($urandom_range(0, 99) < 55)) new_req(1'b1);
            step_round();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
